echo_responder: RTL and testbench

ECHO_RESPONDER -- requirements
Module: echo_responder

---
 rtl/echo_responder.sv | 139 +++++++++++++
 tb/tb_echo_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/echo_responder.sv
// Ultrasonic ranging sensor emulator: validates a trigger pulse, waits out the
// burst time, then returns an echo whose width encodes the latched distance.
module echo_responder #(
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_CYCLES    = 25000,
  parameter int CYCLES_PER_CM   = 2900,
  parameter int MAX_CM          = 400,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       trig,
  input  logic [8:0] distance,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int CW = 21;
  localparam int WW = $clog2(MIN_TRIG_CYCLES + 1);
  localparam logic [WW-1:0] MIN_W = WW'(MIN_TRIG_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG_HI = 3'd1;
  localparam logic [2:0] S_BURST   = 3'd2;
  localparam logic [2:0] S_ECHO    = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  logic          trig_s1_q, trig_s_q;
  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    dist_q, dist_d;
  logic          echo_q, echo_d;
  logic          err_q, err_d;
  logic [CW-1:0] echo_len;

  // Out-of-range or zero distance reports the timeout width instead.
  always_comb begin
    if (dist_q != 9'd0 && dist_q <= 9'(MAX_CM))
      echo_len = CW'(dist_q) * CW'(CYCLES_PER_CM);
    else
      echo_len = CW'(TIMEOUT_CYCLES);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_s_q) begin
          state_d = S_TRIG_HI;
          wcnt_d  = WW'(1);
        end
      end
      S_TRIG_HI: begin
        if (trig_s_q) begin
          if (wcnt_q < MIN_W) wcnt_d = wcnt_q + WW'(1);
        end else if (wcnt_q >= MIN_W) begin
          state_d = S_BURST;
          dist_d  = distance;
          cnt_d   = '0;
          wcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wcnt_d  = '0;
        end
      end
      S_BURST: begin
        if (cnt_q == CW'(BURST_CYCLES - 1)) begin
          state_d = S_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ECHO: begin
        if (cnt_q == echo_len - CW'(1)) begin
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLDOFF: begin
        // A trigger still held at the end of dead time starts a fresh measurement.
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          cnt_d = '0;
          if (trig_s_q) begin
            state_d = S_TRIG_HI;
            wcnt_d  = WW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == S_ECHO);
  end

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      trig_s1_q <= 1'b0;
      trig_s_q  <= 1'b0;
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      dist_q    <= '0;
      echo_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      trig_s1_q <= trig;
      trig_s_q  <= trig_s1_q;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      dist_q    <= dist_d;
      echo_q    <= echo_d;
      err_q     <= err_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = (state_q != S_IDLE);
  assign trig_err = err_q;

endmodule

// File: tb/tb_echo_responder.sv
// Bench for echo_responder: fixed vector table for the corner cases plus
// randomized triggers/distances checked against a timing model.
module tb_echo_responder;

  localparam int MIN   = 4;
  localparam int BRST  = 8;
  localparam int CPC   = 3;
  localparam int MAXC  = 16;
  localparam int TO    = 50;
  localparam int HO    = 10;
  localparam int LIMIT = 100;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic       trig = 1'b0;
  logic [8:0] distance = 9'd0;
  logic       echo, busy, trig_err;

  always #5 clk = ~clk;

  echo_responder #(
    .MIN_TRIG_CYCLES(MIN),
    .BURST_CYCLES(BRST),
    .CYCLES_PER_CM(CPC),
    .MAX_CM(MAXC),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk),
    .clear_b(clear_b),
    .trig(trig),
    .distance(distance),
    .echo(echo),
    .busy(busy),
    .trig_err(trig_err)
  );

  typedef struct {
    int           hi;
    logic [8:0]   d;
    int           chg_at;
    logic [8:0]   d2;
    logic [127:0] mask;
    int           rst_at;
    int           e_err;
    int           e_rise;
    int           e_hi;
    int           e_bf;
    int           e_rises;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int r_err, r_errk, r_rise, r_hi, r_bf, r_rises, r_rst_echo, r_rst_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Echo width implied by the distance rules.
  function automatic int model_width(input int d);
    if (d >= 1 && d <= MAXC) return d * CPC;
    return TO;
  endfunction

  // Drive one trigger of 'hi' cycles, then observe LIMIT edges counted from
  // the first edge that samples trig low (edge 1).
  task automatic run_case(input int hi, input logic [8:0] d, input int chg_at,
                          input logic [8:0] d2, input logic [127:0] mask,
                          input int rst_at);
    logic pe, pb;
    r_err = 0; r_errk = 0; r_rise = 0; r_hi = 0; r_bf = 0; r_rises = 0;
    r_rst_echo = -1; r_rst_busy = -1;
    distance = d;
    trig = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    trig = 1'b0;
    pe = echo;
    pb = busy;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk);
      #1;
      if (trig_err) begin
        r_err++;
        if (r_errk == 0) r_errk = k;
      end
      if (echo) r_hi++;
      if (echo && !pe) begin
        r_rises++;
        if (r_rise == 0) r_rise = k;
      end
      if (!busy && pb && r_bf == 0) r_bf = k;
      if (rst_at != 0 && k == rst_at + 1) begin
        r_rst_echo = int'(echo);
        r_rst_busy = int'(busy);
      end
      pe = echo;
      pb = busy;
      clear_b = !(rst_at != 0 && k == rst_at);
      if (k == chg_at) distance = d2;
      trig = mask[k];
    end
    clear_b = 1'b1;
    trig = 1'b0;
  endtask

  task automatic check_results(input string tag, input int e_err, input int e_rise,
                               input int e_hi, input int e_bf, input int e_rises);
    chk({tag, " trig_err_count"}, r_err, e_err);
    if (e_err != 0) chk({tag, " trig_err_edge"}, r_errk, 3);
    chk({tag, " echo_rise_edge"}, r_rise, e_rise);
    chk({tag, " echo_high_cycles"}, r_hi, e_hi);
    chk({tag, " busy_fall_edge"}, r_bf, e_bf);
    chk({tag, " echo_pulses"}, r_rises, e_rises);
  endtask

  initial begin
    vec_t         tbl[12];
    logic [127:0] m;
    int           hi, w, chg;
    logic [8:0]   d, d2;
    bit           valid;

    m = '0;
    for (int b = 13; b <= 18; b++) m[b] = 1'b1;
    for (int b = 25; b <= 29; b++) m[b] = 1'b1;

    tbl[0]  = '{5, 9'd4,   0, 9'd0,  '0, 0,  0, 11, 12, 33, 1};
    tbl[1]  = '{3, 9'd4,   0, 9'd0,  '0, 0,  1, 0,  0,  3,  0};
    tbl[2]  = '{4, 9'd4,   0, 9'd0,  '0, 0,  0, 11, 12, 33, 1};
    tbl[3]  = '{5, 9'd0,   0, 9'd0,  '0, 0,  0, 11, 50, 71, 1};
    tbl[4]  = '{5, 9'd17,  0, 9'd0,  '0, 0,  0, 11, 50, 71, 1};
    tbl[5]  = '{5, 9'd16,  0, 9'd0,  '0, 0,  0, 11, 48, 69, 1};
    tbl[6]  = '{5, 9'd1,   0, 9'd0,  '0, 0,  0, 11, 3,  24, 1};
    tbl[7]  = '{5, 9'd4,   5, 9'd10, '0, 0,  0, 11, 12, 33, 1};
    tbl[8]  = '{5, 9'd4,   0, 9'd0,  m,  0,  0, 11, 12, 33, 1};
    tbl[9]  = '{5, 9'd4,   0, 9'd0,  '0, 15, 0, 11, 5,  16, 1};
    tbl[10] = '{5, 9'd4,   0, 9'd0,  '0, 0,  0, 11, 12, 33, 1};
    tbl[11] = '{6, 9'd511, 0, 9'd0,  '0, 0,  0, 11, 50, 71, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset echo", int'(echo), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset trig_err", int'(trig_err), 0);
    clear_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_case(tbl[i].hi, tbl[i].d, tbl[i].chg_at, tbl[i].d2, tbl[i].mask, tbl[i].rst_at);
      check_results($sformatf("vec%0d", i), tbl[i].e_err, tbl[i].e_rise,
                    tbl[i].e_hi, tbl[i].e_bf, tbl[i].e_rises);
      if (tbl[i].rst_at != 0) begin
        chk($sformatf("vec%0d echo_on_reset", i), r_rst_echo, 0);
        chk($sformatf("vec%0d busy_on_reset", i), r_rst_busy, 0);
      end
      repeat (3) @(posedge clk);
      #1;
    end

    for (int n = 0; n < 30; n++) begin
      hi  = int'($urandom_range(1, 8));
      d   = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 20));
      d2  = 9'($urandom_range(0, 511));
      chg = int'($urandom_range(3, 10));
      valid = (hi >= MIN);
      w = model_width(int'(d));
      run_case(hi, d, chg, d2, '0, 0);
      check_results($sformatf("rnd%0d(hi=%0d,d=%0d)", n, hi, d),
                    valid ? 0 : 1,
                    valid ? BRST + 3 : 0,
                    valid ? w : 0,
                    valid ? BRST + 3 + w + HO : 3,
                    valid ? 1 : 0);
      repeat (int'($urandom_range(1, 4))) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
